// File: rtl/load_store_ctrl.sv
// load_store_ctrl
//   Sequences mMIPS memory-stage loads/stores onto a word-only data memory.
//   Sub-word stores become read-modify-write; loads are lane-extracted and
//   extended to 32 bits. The core stalls while busy is high.
//
// Parameters
//   SIGNEXT_LB  1 = signed LB sign-extends, 0 = LB zero-extends like LBU
//   BIG_ENDIAN  1 = byte offset 0 lives in bits [31:24]
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   start/store/size/uns  request strobe and operation (size 00 B, 01 H, 10 W)
//   addr, wdata           byte address, right-justified store data
//   busy, done, err       status; err and rdata are valid with done
//   rdata                 extended load data, held until the next load completes
//   mem_req/mem_we        memory request (held until mem_ack) and write enable
//   mem_addr, mem_wdata   word-aligned address and merged write word
//   mem_rdata, mem_ack    read word and one-cycle acknowledge from memory
module load_store_ctrl #(
    parameter bit SIGNEXT_LB = 1'b0,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        store,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    state_t      state, state_nxt;
    logic        store_q, uns_q, err_q, gap_q;
    logic [1:0]  size_q, boff_q;
    logic [15:0] wdata_q;

    logic        bad_req, acked, half_hi;
    logic [1:0]  lane;
    logic [3:0]  lane_mask;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_val, merged;

    assign bad_req = (size == 2'b11) ||
                     (size == SZ_H && addr[0]) ||
                     (size == SZ_W && addr[1:0] != 2'b00);

    // gap_q holds the request low for one cycle after the read half of a
    // read-modify-write, so the memory sees two distinct transactions.
    assign mem_req = (state == READ) || (state == WRITE && !gap_q);
    assign mem_we  = mem_req && (state == WRITE);
    assign acked   = mem_req && mem_ack;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign err     = done && err_q;

    // ---------------- lane selection ----------------
    assign lane      = BIG_ENDIAN ? (2'd3 - boff_q) : boff_q;
    assign half_hi   = (~boff_q[1]) == BIG_ENDIAN;
    assign lane_mask = (size_q == SZ_H) ? (half_hi ? 4'b1100 : 4'b0011)
                                        : (4'b0001 << lane);
    assign byte_val  = mem_rdata[{lane, 3'b000} +: 8];
    assign half_val  = half_hi ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_val = mem_rdata;
        case (size_q)
            SZ_B:    load_val = (SIGNEXT_LB && !uns_q) ? {{24{byte_val[7]}}, byte_val}
                                                      : {24'h0, byte_val};
            SZ_H:    load_val = !uns_q ? {{16{half_val[15]}}, half_val}
                                       : {16'h0, half_val};
            default: load_val = mem_rdata;
        endcase
    end

    // Selected lanes take store data (odd lanes of a half get the upper
    // store byte); all other lanes keep the word just read.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        localparam bit ODD = (i % 2) == 1;
        assign merged[8*i +: 8] = !lane_mask[i]              ? mem_rdata[8*i +: 8] :
                                  (ODD && size_q == SZ_H)    ? wdata_q[15:8]
                                                             : wdata_q[7:0];
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (bad_req)                     state_nxt = DONE;
                    else if (store && size == SZ_W)  state_nxt = WRITE;
                    else                             state_nxt = READ;
                end
            end
            READ:    if (acked) state_nxt = store_q ? WRITE : DONE;
            WRITE:   if (acked) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            store_q   <= 1'b0;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            gap_q     <= 1'b0;
            size_q    <= 2'b00;
            boff_q    <= 2'b00;
            wdata_q   <= 16'h0;
            rdata     <= 32'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
        end else begin
            gap_q <= (state == READ) && acked && store_q;
            case (state)
                IDLE: begin
                    if (start) begin
                        store_q <= store;
                        uns_q   <= uns;
                        size_q  <= size;
                        boff_q  <= addr[1:0];
                        wdata_q <= wdata[15:0];
                        err_q   <= bad_req;
                        // errored accesses leave the memory side untouched
                        if (!bad_req) begin
                            mem_addr <= {addr[31:2], 2'b00};
                            if (store && size == SZ_W) mem_wdata <= wdata;
                        end
                    end
                end
                READ: begin
                    if (acked) begin
                        if (store_q) mem_wdata <= merged;
                        else         rdata     <= load_val;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_ctrl.sv
// Bench for load_store_ctrl: two instances (LB zero-extend / sign-extend)
// run in lockstep against one behavioural word memory. Expected results come
// from an arithmetic model of the access rules kept in ref_mem / exp_rd*.
module tb_load_store_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, store, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    logic        busy0, done0, err0, mem_req, mem_we;
    logic [31:0] rdata0, mem_addr, mem_wdata;
    logic        busy1, done1, err1, mem_req1, mem_we1;
    logic [31:0] rdata1, mem_addr1, mem_wdata1;

    always #5 clk = ~clk;

    load_store_ctrl #(.SIGNEXT_LB(1'b0), .BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .store(store), .size(size),
        .uns(uns), .addr(addr), .wdata(wdata), .busy(busy0), .done(done0),
        .err(err0), .rdata(rdata0), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack));

    load_store_ctrl #(.SIGNEXT_LB(1'b1), .BIG_ENDIAN(1'b1)) dut_se (
        .clk(clk), .rst_n(rst_n), .start(start), .store(store), .size(size),
        .uns(uns), .addr(addr), .wdata(wdata), .busy(busy1), .done(done1),
        .err(err1), .rdata(rdata1), .mem_req(mem_req1), .mem_we(mem_we1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack));

    int vectors = 0, miscompares = 0;
    int ack_a = 1;
    bit junk_ack = 1'b0;
    int n_rd = 0, n_wr = 0, unstable = 0, skew = 0, rw_gap = -1;
    bit [31:0] mem     [bit [29:0]];
    bit [31:0] ref_mem [bit [29:0]];
    logic [31:0] exp_rd0 = 32'h0, exp_rd1 = 32'h0;

    // Memory responder: ack is sampled ack_a edges after the edge on which
    // mem_req rose. Requests are counted when they start.
    int cnt = 0, lowrun = 0;
    bit last_rd = 1'b0;
    logic [31:0] t_addr, t_wdata;
    logic t_we;
    always @(negedge clk) begin
        mem_rdata = $urandom;
        if ({mem_req1, mem_we1, mem_addr1, mem_wdata1, busy1} !==
            {mem_req,  mem_we,  mem_addr,  mem_wdata,  busy0}) skew++;
        if (mem_req !== 1'b1) begin
            cnt = 0;
            lowrun++;
            mem_ack = junk_ack;
        end else begin
            if (cnt == 0) begin
                if (mem_we && last_rd) rw_gap = lowrun;
                if (mem_we) n_wr++; else n_rd++;
                t_addr = mem_addr; t_we = mem_we; t_wdata = mem_wdata;
            end else if (mem_addr !== t_addr || mem_we !== t_we || mem_wdata !== t_wdata) begin
                unstable++;
            end
            lowrun = 0;
            cnt++;
            mem_ack = (cnt == ack_a);
            if (mem_ack) begin
                if (mem_we) begin
                    mem[mem_addr[31:2]] = mem_wdata;
                    last_rd = 1'b0;
                end else begin
                    mem_rdata = mem.exists(mem_addr[31:2]) ? mem[mem_addr[31:2]] : 32'h0;
                    last_rd = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".busy"},      32'(busy0),   32'h0);
        chk({tag, ".done"},      32'(done0),   32'h0);
        chk({tag, ".err"},       32'(err0),    32'h0);
        chk({tag, ".mem_req"},   32'(mem_req), 32'h0);
        chk({tag, ".mem_we"},    32'(mem_we),  32'h0);
        chk({tag, ".rdata"},     rdata0,       32'h0);
        chk({tag, ".rdata_se"},  rdata1,       32'h0);
        chk({tag, ".mem_addr"},  mem_addr,     32'h0);
        chk({tag, ".mem_wdata"}, mem_wdata,    32'h0);
    endtask

    function automatic bit [31:0] rd_mem(input bit [29:0] wi);
        return mem.exists(wi) ? mem[wi] : 32'h0;
    endfunction

    // One access from start to done. Latency is counted in clock edges from
    // the edge that launches start to the edge that registers done.
    task automatic do_op(input string tag, input bit st, input logic [1:0] sz, input bit u,
                         input logic [31:0] a, input logic [31:0] wd, input int ad,
                         input bit poke, output int lat_o);
        bit [29:0]   wi;
        bit [31:0]   w;
        logic [31:0] v;
        bit          e, got;
        int          sh, lat, exp_lat, rd0, wr0, busy_bad;
        wi = a[31:2];
        w  = ref_mem.exists(wi) ? ref_mem[wi] : 32'h0;
        e  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        sh = (sz == 2'b00) ? 8 * (3 - int'(a[1:0])) : (a[1] ? 0 : 16);
        if (e)                         exp_lat = 2;
        else if (!st || sz == 2'b10)   exp_lat = ad + 2;
        else                           exp_lat = 2 * ad + 3;
        if (!e) begin
            if (st) begin
                if (sz == 2'b10)      w = wd;
                else if (sz == 2'b00) w = (w & ~(32'hFF << sh))   | ((wd & 32'hFF)   << sh);
                else                  w = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
                ref_mem[wi] = w;
            end else begin
                v = w >> sh;
                case (sz)
                    2'b00: begin
                        v = v & 32'hFF;
                        exp_rd0 = v;
                        exp_rd1 = (!u && v[7]) ? (v | 32'hFFFFFF00) : v;
                    end
                    2'b01: begin
                        v = v & 32'hFFFF;
                        exp_rd0 = (!u && v[15]) ? (v | 32'hFFFF0000) : v;
                        exp_rd1 = exp_rd0;
                    end
                    default: begin
                        exp_rd0 = w;
                        exp_rd1 = w;
                    end
                endcase
            end
        end

        ack_a = ad; rw_gap = -1; rd0 = n_rd; wr0 = n_wr; busy_bad = 0;
        store = st; size = sz; uns = u; addr = a; wdata = wd; start = 1'b1;
        got = 1'b0; lat = 0;
        while (!got && lat < 200) begin
            tick();
            lat++;
            start = 1'b0;
            // stray request with unrelated operands while the access is in flight
            if (poke && exp_lat >= 5 && lat == 2) begin
                start = 1'b1; store = ~st; size = 2'b10; uns = ~u; addr = ~a; wdata = ~wd;
            end
            if (busy0 !== 1'b1) busy_bad++;
            if (done0 === 1'b1) got = 1'b1;
        end
        start = 1'b0;
        lat_o = lat + 1;
        chk({tag, ".done_seen"}, 32'(got), 32'h1);
        if (got) begin
            chk({tag, ".latency"},  lat + 1,          exp_lat);
            chk({tag, ".done_se"},  32'(done1),       32'h1);
            chk({tag, ".err"},      32'(err0),        32'(e));
            chk({tag, ".err_se"},   32'(err1),        32'(e));
            chk({tag, ".rdata"},    rdata0,           exp_rd0);
            chk({tag, ".rdata_se"}, rdata1,           exp_rd1);
            chk({tag, ".memword"},  rd_mem(wi),       ref_mem.exists(wi) ? ref_mem[wi] : 32'h0);
            chk({tag, ".reads"},    n_rd - rd0,       (!e && !(st && sz == 2'b10)) ? 1 : 0);
            chk({tag, ".writes"},   n_wr - wr0,       (!e && st) ? 1 : 0);
            chk({tag, ".busy"},     busy_bad,         0);
            if (!e && st && sz != 2'b10) chk({tag, ".rw_gap"}, rw_gap, 1);
        end
        tick();
        chk({tag, ".done_pulse"}, 32'({done0, busy0}), 32'h0);
    endtask

    initial begin
        logic [31:0] ra, rwd;
        logic [1:0]  rsz;
        bit          rs, ru, rp;
        int          rad, n, lat;

        rst_n = 1'b0; start = 1'b0; store = 1'b0; size = 2'b00; uns = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            mem[30'h40 + 30'(i)] = ra; ref_mem[30'h40 + 30'(i)] = ra;
            ra = $urandom;
            mem[30'h80 + 30'(i)] = ra; ref_mem[30'h80 + 30'(i)] = ra;
        end
        tick(); tick();
        chk_reset("reset");
        rst_n = 1'b1;
        tick();

        // sub-word loads on 0x80F1_7F22, single-cycle ack
        mem[30'h40] = 32'h80F17F22; ref_mem[30'h40] = 32'h80F17F22;
        do_op("lb_100", 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 1, 1'b0, lat);
        chk("lb_100.const", rdata0, 32'h00000080);
        chk("lb_100.lat3", lat, 3);
        do_op("lh_102", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1, 1'b0, lat);
        chk("lh_102.const", rdata0, 32'h00007F22);
        do_op("lh_100", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 1, 1'b0, lat);
        chk("lh_100.const", rdata0, 32'hFFFF80F1);
        do_op("lhu_100", 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 1, 1'b0, lat);
        chk("lhu_100.const", rdata0, 32'h000080F1);
        do_op("lb_101", 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 1, 1'b0, lat);
        chk("lb_101.se_const", rdata1, 32'hFFFFFFF1);
        do_op("lbu_101", 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 1, 1'b0, lat);
        chk("lbu_101.se_const", rdata1, 32'h000000F1);

        // read-modify-write stores on 0x1122_3344
        mem[30'h80] = 32'h11223344; ref_mem[30'h80] = 32'h11223344;
        do_op("sb_201", 1'b1, 2'b00, 1'b0, 32'h201, 32'h000000AB, 1, 1'b0, lat);
        chk("sb_201.mem_wdata", mem_wdata, 32'h11AB3344);
        mem[30'h80] = 32'h11223344; ref_mem[30'h80] = 32'h11223344;
        do_op("sh_202", 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000BEEF, 1, 1'b0, lat);
        chk("sh_202.mem_wdata", mem_wdata, 32'h1122BEEF);
        do_op("sw_204", 1'b1, 2'b10, 1'b0, 32'h204, 32'hCAFEF00D, 2, 1'b0, lat);

        // misaligned / reserved
        do_op("lw_102", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1, 1'b0, lat);
        do_op("sh_101", 1'b1, 2'b01, 1'b0, 32'h101, 32'h1234, 1, 1'b0, lat);
        do_op("sz_11",  1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1, 1'b0, lat);
        chk("sz_11.lat2", lat, 2);

        // slow memory with a stray start mid-transaction
        do_op("sb_a5", 1'b1, 2'b00, 1'b0, 32'h202, 32'h000000C3, 5, 1'b1, lat);
        chk("sb_a5.lat13", lat, 13);

        // reset while the write half of an SB is outstanding
        mem[30'h80] = 32'h11223344; ref_mem[30'h80] = 32'h11223344;
        ack_a = 5; store = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h203; wdata = 32'h5A;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(mem_req === 1'b1 && mem_we === 1'b1) && n < 100) begin
            tick();
            n++;
        end
        chk("rst_mid.reached_write", 32'(mem_req && mem_we), 32'h1);
        rst_n = 1'b0;
        tick();
        chk_reset("rst_mid");
        rst_n = 1'b1;
        chk("rst_mid.memword", rd_mem(30'h80), 32'h11223344);
        exp_rd0 = 32'h0; exp_rd1 = 32'h0;
        tick();
        do_op("lw_200", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 2, 1'b0, lat);
        chk("lw_200.const", rdata0, 32'h11223344);

        // randomized accesses, with spurious acks while no request is pending
        for (int k = 0; k < 40; k++) begin
            ra  = 32'h100 + ($urandom % 64);
            rs  = 1'($urandom % 2);
            ru  = 1'($urandom % 2);
            rp  = 1'($urandom % 2);
            rsz = 2'($urandom % 4);
            rwd = $urandom;
            rad = 1 + int'($urandom % 4);
            junk_ack = ($urandom % 3) == 0;
            do_op("rnd", rs, rsz, ru, ra, rwd, rad, rp, lat);
        end
        junk_ack = 1'b0;

        chk("mem_side.stable", unstable, 0);
        chk("instances.lockstep", skew, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
